aes_core_arbiter: RTL
=====================

Name: aes_core_arbiter

Overview:
Shares a single aes_cipher_top encryption core between NUM_REQ independent requesters using round-robin arbitration. It captures a winning request's key and plaintext, then pulses the core's load, and waits for the core's done pulse. The ciphertext is returned through a valid/ready response channel tagged with the requester ID. A watchdog covers a core that never signals done. The block sits directly in front of aes_cipher_top; the integration level ties the core's active-low reset to the inverted rst.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the requester ID
TIMEOUT, 32, cycles in RUN without core_done before an error response is issued (must be greater than the core latency)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_key  in  NUM_REQ*128  packed keys; requester i at [i*128 +: 128]
req_text  in  NUM_REQ*128  packed plaintexts; same packing
core_ld  out  1  load pulse to the core
core_key  out  128  key to the core
core_text_in  out  128  plaintext to the core
core_text_out  in  128  ciphertext from the core
core_done  in  1  completion pulse from the core
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester ID of the response
rsp_data  out  128  ciphertext, or 0 on error
rsp_err  out  1  1 = watchdog timeout
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; key/text registers 0; watchdog 0; last_grant=NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - Grant g is the first asserted req_valid searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; this is the handshake.
  - Capture req_key[g] and req_text[g] into registers, store g as the current ID, go to LOAD.
  - If no req_valid is asserted, stay in IDLE; req_ready=0.
- LOAD (1 cycle):
  - core_ld=1; clear the watchdog; go to RUN.
  - core_done is ignored in this state.
- RUN:
  - core_ld=0; core_key and core_text_in hold the captured values from LOAD until the block leaves RESP.
  - core_done=1: register core_text_out into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 with no done: rsp_data=0, rsp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable until the handshake.
  - On rsp_valid and rsp_ready: last_grant=current ID, rsp_valid=0 next cycle, go to IDLE.
  - Backpressure may last indefinitely; no new request is granted while in RESP.
  - A late core_done arriving in RESP is ignored.
- Fairness: last_grant updates only on response completion. A requester holding req_valid is served within NUM_REQ transactions.
- Requesters must hold req_valid, key and text stable until req_ready. The arbiter never drops a request once it has asserted req_ready.
- Minimum transaction length: IDLE(1) + LOAD(1) + core latency + RESP(≥1).
- Reset asserted mid-RUN or mid-RESP: the transaction is aborted, no response is issued, and core_ld stays 0.

Decomposition:
- Package aes_ctrl_pkg: AES_BLK_W=128; state enum {IDLE, LOAD, RUN, RESP}; function to extract the i-th 128-bit slice.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin priority pick from the request vector and last_grant. It is purely combinational and outputs a one-hot grant plus the encoded ID.
- All sequencing lives in aes_core_arbiter.

Test Plan:
1. Single request: requester 0 with key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff -> one core_ld pulse; rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
2. All 4 requesters valid simultaneously; requester 2 uses key 2b7e151628aed2a6abf7158809cf4f3c and pt 6bc1bee22e409f96e93d7e117393172a -> grant order 0,1,2,3; requester 2's response is 3ad77bb40d7a3660a89ecaf32466ef97; exactly one req_ready bit at a time.
3. Fairness: requesters 1 and 3 held valid continuously for 6 transactions -> rsp_id sequence 1,3,1,3,1,3.
4. Backpressure: rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data stay constant; no req_ready and no core_ld until the handshake; the next grant follows in the cycle after returning to IDLE.
5. Timeout: core model never asserts done -> RESP entered TIMEOUT cycles after LOAD with rsp_err=1 and rsp_data=0; the next request completes normally.
6. Async reset asserted mid-RUN -> outputs clear immediately without waiting for a clock edge; after release, requester 0 wins first and no stale response appears.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and helpers for the AES core arbiter
package aes_ctrl_pkg;

  localparam int AES_BLK_W = 128;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_e;

  // Callers zero-extend their packed request bus to MAX_REQ blocks first.
  function automatic logic [AES_BLK_W-1:0] blk_slice(
    input logic [MAX_REQ*AES_BLK_W-1:0] vec,
    input int unsigned                  idx
  );
    return vec[idx*AES_BLK_W +: AES_BLK_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - shares one AES core among NUM_REQ requesters with a watchdog
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_text,
  output logic                         core_ld,
  output logic [AES_BLK_W-1:0]         core_key,
  output logic [AES_BLK_W-1:0]         core_text_in,
  input  logic [AES_BLK_W-1:0]         core_text_out,
  input  logic                         core_done,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [AES_BLK_W-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_e                       state;
  logic [ID_W-1:0]              last_grant;
  logic [ID_W-1:0]              cur_id;
  logic [AES_BLK_W-1:0]         key_q;
  logic [AES_BLK_W-1:0]         text_q;
  logic [WD_W-1:0]              wdog;
  logic [WD_W-1:0]              wdog_inc;
  logic [MAX_REQ*AES_BLK_W-1:0] key_ext;
  logic [MAX_REQ*AES_BLK_W-1:0] text_ext;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_W-1:0]              grant_id;
  logic                         grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_any  (grant_any)
  );

  always_comb begin
    key_ext  = '0;
    text_ext = '0;
    key_ext[NUM_REQ*AES_BLK_W-1:0]  = req_key;
    text_ext[NUM_REQ*AES_BLK_W-1:0] = req_text;
  end

  // The accept strobe is the handshake itself, so it must vanish the instant reset asserts.
  assign req_ready    = (state == IDLE && !rst) ? grant : '0;
  assign busy         = (state != IDLE);
  assign rsp_id       = cur_id;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign wdog_inc     = wdog + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      key_q      <= '0;
      text_q     <= '0;
      wdog       <= '0;
      core_ld    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            key_q   <= blk_slice(key_ext, int'(grant_id));
            text_q  <= blk_slice(text_ext, int'(grant_id));
            cur_id  <= grant_id;
            core_ld <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          core_ld <= 1'b0;
          wdog    <= '0;
          state   <= RUN;
        end
        RUN: begin
          // Testing the incremented count lands RESP exactly TIMEOUT cycles after LOAD.
          if (core_done) begin
            rsp_data  <= core_text_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wdog_inc == WD_W'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wdog <= wdog_inc;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= cur_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
